cpu_controller: RTL and testbench

Multi-cycle control unit that sits directly upstream of the CPU datapath. It fetches 16-bit instructions from a synchronous-read memory, holds them in an instruction register and drives every datapath control input: register write enables, operand mux selects, immediate select, ALU control word and flag enable. It also owns the program counter, steers the memory address between PC and register-addressed load/store, and resolves conditional branches and jumps from the datapath flag register.

---
 rtl/cpu_controller.sv | 152 +++++++++++++++
 tb/tb_cpu_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: fetches 16-bit instructions, owns PC/IR and drives every datapath control input.
// Latency: 3 cycles for ALU/store/branch/jump/NOP, 4 cycles for LOAD.
// No backpressure: memory is fixed 1-cycle synchronous read, and strobes are consumed in the cycle they assert.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MemData,
    input  logic [4:0]  Flags,
    input  logic [15:0] AluBusB,
    output logic [15:0] PC,
    output logic        AddrSel,
    output logic        MemWrite,
    output logic        LdSel,
    output logic [15:0] RegEnable,
    output logic [3:0]  MuxControlA,
    output logic [3:0]  MuxControlB,
    output logic        MuxControlC,
    output logic [15:0] AluControl,
    output logic        FlagEnable
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, LDWB} state_t;

    state_t      state, nextState;
    logic [15:0] ir, nextIr, nextPc;

    // Instruction fields
    logic [3:0]  op, rdest, ext;
    logic [15:0] disp;
    assign op    = ir[15:12];
    assign rdest = ir[11:8];
    assign ext   = ir[7:4];
    assign disp  = {{8{ir[7]}}, ir[7:0]};

    // Instruction classes; op 0100 is the memory/jump group, anything else outside ALU/Bcond is immediate ALU
    logic isRegAlu, isMemGrp, isLoad, isStor, isJcond, isBcond, isImmAlu, isCmp;
    assign isRegAlu = (op == 4'b0000);
    assign isMemGrp = (op == 4'b0100);
    assign isLoad   = isMemGrp && (ext == 4'b0000);
    assign isStor   = isMemGrp && (ext == 4'b0100);
    assign isJcond  = isMemGrp && (ext == 4'b1100);
    assign isBcond  = (op == 4'b1100);
    assign isImmAlu = !isRegAlu && !isMemGrp && !isBcond;
    assign isCmp    = (isRegAlu && ext == 4'b1011) || (op == 4'b1011);

    // IR-derived selects are valid for the whole instruction
    assign MuxControlA = rdest;
    assign MuxControlB = ir[3:0];
    assign MuxControlC = isImmAlu;
    assign AluControl  = ir;

    // Flag bits in {C,L,F,Z,N} order
    logic flagC, flagL, flagF, flagZ, flagN, taken;
    assign flagC = Flags[4];
    assign flagL = Flags[3];
    assign flagF = Flags[2];
    assign flagZ = Flags[1];
    assign flagN = Flags[0];

    // Condition code evaluation for Bcond/Jcond
    always_comb begin
        taken = 1'b0;
        case (rdest)
            4'h0: taken = flagZ;
            4'h1: taken = !flagZ;
            4'h2: taken = flagC;
            4'h3: taken = !flagC;
            4'h4: taken = flagL;
            4'h5: taken = !flagL;
            4'h6: taken = flagN;
            4'h7: taken = !flagN;
            4'h8: taken = flagF;
            4'h9: taken = !flagF;
            4'hA: taken = !flagL && !flagZ;
            4'hB: taken = flagL || flagZ;
            4'hC: taken = !flagN && !flagZ;
            4'hD: taken = flagN || flagZ;
            4'hE: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, PC/IR update and control strobes
    always_comb begin
        nextState  = state;
        nextIr     = ir;
        nextPc     = PC;
        AddrSel    = 1'b0;
        MemWrite   = 1'b0;
        LdSel      = 1'b0;
        RegEnable  = 16'h0000;
        FlagEnable = 1'b0;
        case (state)
            FETCH: nextState = DECODE;
            DECODE: begin
                nextIr    = MemData;
                nextState = EXEC;
            end
            EXEC: begin
                nextState = FETCH;
                if (isLoad) begin
                    AddrSel   = 1'b1;
                    nextState = LDWB;
                end else if (isStor) begin
                    AddrSel  = 1'b1;
                    MemWrite = 1'b1;
                    nextPc   = PC + 16'd1;
                end else if (isBcond) begin
                    nextPc = taken ? PC + disp : PC + 16'd1;
                end else if (isJcond) begin
                    nextPc = taken ? AluBusB : PC + 16'd1;
                end else if (isMemGrp) begin
                    nextPc = PC + 16'd1;
                end else begin
                    RegEnable  = isCmp ? 16'h0000 : (16'h0001 << rdest);
                    FlagEnable = 1'b1;
                    nextPc     = PC + 16'd1;
                end
            end
            LDWB: begin
                AddrSel   = 1'b1;
                LdSel     = 1'b1;
                RegEnable = 16'h0001 << rdest;
                nextPc    = PC + 16'd1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
        // Reset squashes any write in flight, including a store in EXEC or the load writeback
        if (reset) begin
            AddrSel    = 1'b0;
            MemWrite   = 1'b0;
            LdSel      = 1'b0;
            RegEnable  = 16'h0000;
            FlagEnable = 1'b0;
        end
    end

    // State, PC and IR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            PC    <= 16'h0000;
            ir    <= 16'h0000;
        end else begin
            state <= nextState;
            PC    <= nextPc;
            ir    <= nextIr;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instruction vectors, per-cycle expected outputs queued and compared.
// Latency under test: 3-cycle instructions and 4-cycle LOAD, plus reset mid-store.
// No backpressure at the interface; a behavioural 1-cycle memory feeds MemData.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] MemData;
    logic [4:0]  Flags;
    logic [15:0] AluBusB;
    logic [15:0] PC;
    logic        AddrSel, MemWrite, LdSel, MuxControlC, FlagEnable;
    logic [15:0] RegEnable, AluControl;
    logic [3:0]  MuxControlA, MuxControlB;

    cpu_controller dut (
        .clk(clk), .reset(reset), .MemData(MemData), .Flags(Flags), .AluBusB(AluBusB),
        .PC(PC), .AddrSel(AddrSel), .MemWrite(MemWrite), .LdSel(LdSel),
        .RegEnable(RegEnable), .MuxControlA(MuxControlA), .MuxControlB(MuxControlB),
        .MuxControlC(MuxControlC), .AluControl(AluControl), .FlagEnable(FlagEnable)
    );

    always #5 clk = ~clk;

    // Instruction memory: returns the current instruction for PC fetches, a data word otherwise
    logic [15:0] instr = 16'h0000;
    always @(posedge clk) MemData <= AddrSel ? 16'hBEEF : instr;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        addrSel, memWrite, ldSel;
        logic [15:0] regEn;
        logic [15:0] aluCtl;
        logic        muxC, flagEn;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nFails  = 0;

    logic [15:0] curPc    = 16'h0000;
    logic [15:0] prevIr   = 16'h0000;
    logic        prevMuxC = 1'b0;

    task automatic check(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end
    endtask

    // Compare one expected cycle whenever one is queued
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, "PC",          PC,                 e.pc);
            check(e.name, "AddrSel",     {15'd0, AddrSel},   {15'd0, e.addrSel});
            check(e.name, "MemWrite",    {15'd0, MemWrite},  {15'd0, e.memWrite});
            check(e.name, "LdSel",       {15'd0, LdSel},     {15'd0, e.ldSel});
            check(e.name, "RegEnable",   RegEnable,          e.regEn);
            check(e.name, "AluControl",  AluControl,         e.aluCtl);
            check(e.name, "MuxControlA", {12'd0, MuxControlA}, {12'd0, e.aluCtl[11:8]});
            check(e.name, "MuxControlB", {12'd0, MuxControlB}, {12'd0, e.aluCtl[3:0]});
            check(e.name, "MuxControlC", {15'd0, MuxControlC}, {15'd0, e.muxC});
            check(e.name, "FlagEnable",  {15'd0, FlagEnable},  {15'd0, e.flagEn});
        end
    end

    task automatic pushRec(input string nm, input logic [15:0] pc, input logic as, input logic mw,
                           input logic ls, input logic [15:0] re, input logic [15:0] ac,
                           input logic mc, input logic fe);
        exp_t e;
        e.name = nm; e.pc = pc; e.addrSel = as; e.memWrite = mw; e.ldSel = ls;
        e.regEn = re; e.aluCtl = ac; e.muxC = mc; e.flagEn = fe;
        q.push_back(e);
    endtask

    // kind: 0 = single EXEC cycle, 1 = LOAD (EXEC + LDWB), 2 = STOR
    task automatic runInstr(input string nm, input logic [15:0] ir, input logic mc,
                            input logic [15:0] re, input logic fe, input int kind,
                            input logic [15:0] busB, input logic [4:0] fl, input logic [15:0] nextPc);
        instr   = ir;
        AluBusB = busB;
        Flags   = fl;
        pushRec({nm, "/fetch"},  curPc, 1'b0, 1'b0, 1'b0, 16'h0, prevIr, prevMuxC, 1'b0);
        pushRec({nm, "/decode"}, curPc, 1'b0, 1'b0, 1'b0, 16'h0, prevIr, prevMuxC, 1'b0);
        case (kind)
            1: begin
                pushRec({nm, "/exec"}, curPc, 1'b1, 1'b0, 1'b0, 16'h0, ir, mc, 1'b0);
                pushRec({nm, "/ldwb"}, curPc, 1'b1, 1'b0, 1'b1, re,    ir, mc, 1'b0);
            end
            2: pushRec({nm, "/exec"}, curPc, 1'b1, 1'b1, 1'b0, 16'h0, ir, mc, 1'b0);
            default: pushRec({nm, "/exec"}, curPc, 1'b0, 1'b0, 1'b0, re, ir, mc, fe);
        endcase
        repeat ((kind == 1) ? 4 : 3) @(posedge clk);
        #1;
        curPc    = nextPc;
        prevIr   = ir;
        prevMuxC = mc;
    endtask

    initial begin
        reset   = 1'b1;
        Flags   = 5'b0;
        AluBusB = 16'h0;
        @(posedge clk); #1;
        pushRec("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        //        name        IR        muxC  RegEnable  FlagEn kind AluBusB   Flags     next PC
        runInstr("addi_r3",  16'h5305, 1'b1, 16'h0008, 1'b1, 0, 16'h0000, 5'b00000, 16'h0001);
        runInstr("cmp",      16'h01B2, 1'b0, 16'h0000, 1'b1, 0, 16'h0000, 5'b00000, 16'h0002);
        runInstr("add_r1",   16'h0152, 1'b0, 16'h0002, 1'b1, 0, 16'h0000, 5'b00000, 16'h0003);
        runInstr("cmpi",     16'hB107, 1'b1, 16'h0000, 1'b1, 0, 16'h0000, 5'b00000, 16'h0004);
        runInstr("load_r4",  16'h4402, 1'b0, 16'h0010, 1'b0, 1, 16'h0040, 5'b00000, 16'h0005);
        runInstr("stor",     16'h4142, 1'b0, 16'h0000, 1'b0, 2, 16'h0040, 5'b00000, 16'h0006);
        runInstr("nop",      16'h4030, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 5'b00000, 16'h0007);
        runInstr("juc_10a",  16'h4EC5, 1'b0, 16'h0000, 1'b0, 0, 16'h0010, 5'b00000, 16'h0010);
        runInstr("beq_tkn",  16'hC0FE, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 5'b00010, 16'h000E);
        runInstr("juc_10b",  16'h4EC5, 1'b0, 16'h0000, 1'b0, 0, 16'h0010, 5'b00000, 16'h0010);
        runInstr("beq_ntkn", 16'hC0FE, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 5'b00000, 16'h0011);
        runInstr("juc_ffff", 16'h4EC5, 1'b0, 16'h0000, 1'b0, 0, 16'hFFFF, 5'b00000, 16'hFFFF);
        runInstr("buc_wrap", 16'hCE02, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 5'b00000, 16'h0001);
        runInstr("juc_1234", 16'h4EC5, 1'b0, 16'h0000, 1'b0, 0, 16'h1234, 5'b00000, 16'h1234);
        runInstr("jfalse",   16'h4FC5, 1'b0, 16'h0000, 1'b0, 0, 16'h5555, 5'b11111, 16'h1235);
        runInstr("blo_tkn",  16'hCA03, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 5'b00000, 16'h1238);
        runInstr("bgt_ntkn", 16'hC605, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 5'b00000, 16'h1239);

        // Store interrupted by a 2-cycle reset starting in its EXEC cycle
        instr   = 16'h4142;
        AluBusB = 16'h0040;
        pushRec("rst_stor/fetch",  curPc, 1'b0, 1'b0, 1'b0, 16'h0, prevIr, prevMuxC, 1'b0);
        pushRec("rst_stor/decode", curPc, 1'b0, 1'b0, 1'b0, 16'h0, prevIr, prevMuxC, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        pushRec("rst_stor/exec",   curPc, 1'b0, 1'b0, 1'b0, 16'h0, 16'h4142, 1'b0, 1'b0);
        @(posedge clk); #1;
        pushRec("rst_stor/hold",   16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset    = 1'b0;
        curPc    = 16'h0000;
        prevIr   = 16'h0000;
        prevMuxC = 1'b0;

        runInstr("addi_post", 16'h5305, 1'b1, 16'h0008, 1'b1, 0, 16'h0000, 5'b00000, 16'h0001);
        pushRec("final", curPc, 1'b0, 1'b0, 1'b0, 16'h0, prevIr, prevMuxC, 1'b0);
        @(negedge clk); #1;

        nChecks++;
        if (q.size() != 0) begin
            nFails++;
            $display("FAIL drain: %0d expected cycles left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
